// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like bus between the fetch port (reads) and the data port (reads/writes).
// One transaction at a time: IDLE grants, ADDR waits for addr_ok, DATA waits for data_ok, DONE pulses.
module sram_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_cancel,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              stall_i,
  output logic              stall_d,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_e;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_owner_q, last_owner_d;
  logic                cancelled_q, cancelled_d;
  logic                wr_q, wr_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                grant_d, grant_i, capture;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_I;
      last_owner_q <= OWN_I;
      cancelled_q  <= 1'b0;
      wr_q         <= 1'b0;
      size_q       <= 2'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cancelled_q  <= cancelled_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cancelled_d  = cancelled_q;
    wr_d         = wr_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    capture      = 1'b0;
    // Data wins unless round-robin says fetch was not the last owner and fetch is asking.
    grant_d = d_req && (DATA_FIRST || (last_owner_q == OWN_I) || !i_req);
    grant_i = !grant_d && i_req && !i_cancel;
    case (state_q)
      S_IDLE: begin
        if (grant_d) begin
          owner_d     = OWN_D;
          wr_d        = d_wr;
          size_d      = d_size;
          addr_d      = d_addr;
          wdata_d     = d_wdata;
          cancelled_d = 1'b0;
          state_d     = S_ADDR;
        end else if (grant_i) begin
          owner_d     = OWN_I;
          wr_d        = 1'b0;
          size_d      = 2'd2;
          addr_d      = i_addr;
          wdata_d     = '0;
          cancelled_d = 1'b0;
          state_d     = S_ADDR;
        end
      end
      S_ADDR: begin
        if (bus_addr_ok) begin
          if (bus_data_ok) begin
            capture = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (bus_data_ok) begin
          capture = 1'b1;
          state_d = S_DONE;
        end
      end
      default: begin
        last_owner_d = owner_q;
        state_d      = S_IDLE;
      end
    endcase
    // A flushed fetch keeps its bus transaction alive but loses its completion pulse.
    if ((state_q == S_ADDR || state_q == S_DATA) && owner_q == OWN_I && i_cancel)
      cancelled_d = 1'b1;
    if (capture) begin
      if (owner_q == OWN_I)
        i_rdata_d = bus_rdata;
      else if (!wr_q)
        d_rdata_d = bus_rdata;
    end
  end

  always_comb begin
    bus_req     = (state_q == S_ADDR);
    bus_wr      = wr_q;
    bus_size    = size_q;
    bus_addr    = addr_q;
    bus_wdata   = wdata_q;
    i_done      = (state_q == S_DONE) && (owner_q == OWN_I) && !cancelled_q;
    d_done      = (state_q == S_DONE) && (owner_q == OWN_D);
    stall_i     = i_req && !i_done;
    stall_d     = d_req && !d_done;
    i_rdata     = i_rdata_q;
    d_rdata     = d_rdata_q;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: one instance with data priority, one with round-robin grants.
// The bench plays both requesters and the bus slave; timing is predicted from slave delays.
module tb_sram_bus_arbiter;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_cancel;
    logic        d_req;
    logic        d_wr;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
  } drv_t;

  typedef struct packed {
    logic [31:0] i_rdata;
    logic        i_done;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        stall_i;
    logic        stall_d;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [1:0]  dbg;
  } mon_t;

  typedef struct {
    int          k;
    bit          ri, rd, wr;
    logic [1:0]  sz;
    logic [31:0] ia, da, wd, ird, drd;
    int          ai, bi, li, ad, bd, ld, cc;
    bit          d_first;
  } vec_t;

  drv_t drv [2];
  mon_t mon [2];
  bit   last [2];
  int   n_vec = 0;
  int   n_bad = 0;

  logic [31:0] ir_a, dr_a, ba_a, bwd_a, ir_b, dr_b, ba_b, bwd_b;
  logic        id_a, dd_a, si_a, sd_a, br_a, bw_a, id_b, dd_b, si_b, sd_b, br_b, bw_b;
  logic [1:0]  bs_a, dbg_a, bs_b, dbg_b;

  always_comb begin
    mon[0] = {ir_a, id_a, dr_a, dd_a, si_a, sd_a, br_a, bw_a, bs_a, ba_a, bwd_a, dbg_a};
    mon[1] = {ir_b, id_b, dr_b, dd_b, si_b, sd_b, br_b, bw_b, bs_b, ba_b, bwd_b, dbg_b};
  end

  sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_FIRST(1'b1)) dut_a (
    .clk(clk), .resetn(resetn),
    .i_req(drv[0].i_req), .i_addr(drv[0].i_addr), .i_cancel(drv[0].i_cancel),
    .i_rdata(ir_a), .i_done(id_a),
    .d_req(drv[0].d_req), .d_wr(drv[0].d_wr), .d_size(drv[0].d_size),
    .d_addr(drv[0].d_addr), .d_wdata(drv[0].d_wdata),
    .d_rdata(dr_a), .d_done(dd_a), .stall_i(si_a), .stall_d(sd_a),
    .bus_req(br_a), .bus_wr(bw_a), .bus_size(bs_a), .bus_addr(ba_a), .bus_wdata(bwd_a),
    .bus_addr_ok(drv[0].addr_ok), .bus_data_ok(drv[0].data_ok), .bus_rdata(drv[0].rdata),
    .dbg_state_o(dbg_a)
  );

  sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_FIRST(1'b0)) dut_b (
    .clk(clk), .resetn(resetn),
    .i_req(drv[1].i_req), .i_addr(drv[1].i_addr), .i_cancel(drv[1].i_cancel),
    .i_rdata(ir_b), .i_done(id_b),
    .d_req(drv[1].d_req), .d_wr(drv[1].d_wr), .d_size(drv[1].d_size),
    .d_addr(drv[1].d_addr), .d_wdata(drv[1].d_wdata),
    .d_rdata(dr_b), .d_done(dd_b), .stall_i(si_b), .stall_d(sd_b),
    .bus_req(br_b), .bus_wr(bw_b), .bus_size(bs_b), .bus_addr(ba_b), .bus_wdata(bwd_b),
    .bus_addr_ok(drv[1].addr_ok), .bus_data_ok(drv[1].data_ok), .bus_rdata(drv[1].rdata),
    .dbg_state_o(dbg_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input int k, input string tag);
    mon_t m;
    m = mon[k];
    chk($sformatf("%s k%0d bus_req", tag, k), 32'(m.bus_req), 32'd0);
    chk($sformatf("%s k%0d wr/size", tag, k), 32'({m.bus_wr, m.bus_size}), 32'd0);
    chk($sformatf("%s k%0d bus_addr", tag, k), m.bus_addr, 32'd0);
    chk($sformatf("%s k%0d bus_wdata", tag, k), m.bus_wdata, 32'd0);
    chk($sformatf("%s k%0d i_rdata", tag, k), m.i_rdata, 32'd0);
    chk($sformatf("%s k%0d d_rdata", tag, k), m.d_rdata, 32'd0);
    chk($sformatf("%s k%0d dones", tag, k), 32'({m.i_done, m.d_done}), 32'd0);
    chk($sformatf("%s k%0d state", tag, k), 32'(m.dbg), 32'd0);
  endtask

  // Runs one granted transaction; cycle 0 (the grant cycle) has already been driven.
  // Slave gives addr_ok in cycle a+1 and data_ok b cycles later (b=0: same cycle).
  task automatic serve(input int k, input bit pd, input int a, input int b, input int lat,
                       input int ccyc, input bit wr, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd);
    bit   canc, ei, ed, ok_a, ok_d;
    int   nreq;
    mon_t m;
    canc = !pd && ccyc >= 1 && ccyc < lat;
    nreq = 0;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      m  = mon[k];
      ei = (c == lat) && !pd && !canc;
      ed = (c == lat) && pd;
      if (m.bus_req) nreq++;
      chk($sformatf("k%0d c%0d done pulses", k, c), 32'({m.i_done, m.d_done}), 32'({ei, ed}));
      if (c == 1) chk($sformatf("k%0d bus_req first", k), 32'(m.bus_req), 32'd1);
      if (c == 1 || c == lat) begin
        chk($sformatf("k%0d c%0d bus_addr", k, c), m.bus_addr, addr);
        chk($sformatf("k%0d c%0d wr/size", k, c), 32'({m.bus_wr, m.bus_size}), 32'({wr, sz}));
        if (pd) chk($sformatf("k%0d c%0d bus_wdata", k, c), m.bus_wdata, wd);
      end
      if (c == lat && !wr && !canc)
        chk($sformatf("k%0d rdata", k), pd ? m.d_rdata : m.i_rdata, rd);
      if (canc && c == ccyc + 1) drv[k].i_req = 1'b0;
      drv[k].i_cancel = !pd && (c == ccyc);
      ok_a = (c == a + 1);
      ok_d = (b == 0) ? ok_a : (c == a + 1 + b);
      drv[k].addr_ok = ok_a;
      drv[k].data_ok = ok_d;
      drv[k].rdata   = ok_d ? rd : $urandom;
      if (c == 1 || c == lat) begin
        #1;
        m = mon[k];
        if (pd) chk($sformatf("k%0d c%0d stall_d", k, c), 32'(m.stall_d), 32'(drv[k].d_req && !ed));
        else    chk($sformatf("k%0d c%0d stall_i", k, c), 32'(m.stall_i), 32'(drv[k].i_req && !ei));
      end
    end
    chk($sformatf("k%0d bus_req cycles", k), 32'(nreq), 32'(a + 1));
  endtask

  task automatic serve_i(input vec_t v);
    serve(v.k, 1'b0, v.ai, v.bi, v.li, v.cc, 1'b0, 2'd2, v.ia, 32'd0, v.ird);
    last[v.k] = 1'b0;
  endtask

  task automatic serve_d(input vec_t v);
    serve(v.k, 1'b1, v.ad, v.bd, v.ld, 0, v.wr, v.sz, v.da, v.wd, v.drd);
    last[v.k] = 1'b1;
  endtask

  // Presents both requests in one IDLE cycle; winner is served, then the held loser.
  task automatic round(input vec_t v);
    int k;
    k = v.k;
    @(negedge clk);
    drv[k].i_req = v.ri;  drv[k].i_addr = v.ia;  drv[k].i_cancel = 1'b0;
    drv[k].d_req = v.rd;  drv[k].d_wr = v.wr;    drv[k].d_size = v.sz;
    drv[k].d_addr = v.da; drv[k].d_wdata = v.wd;
    drv[k].addr_ok = 1'b0; drv[k].data_ok = 1'b0;
    #1;
    chk($sformatf("k%0d idle stalls", k), 32'({mon[k].stall_i, mon[k].stall_d}), 32'({v.ri, v.rd}));
    if (v.d_first) serve_d(v); else serve_i(v);
    @(negedge clk);
    if (v.d_first) drv[k].d_req = 1'b0; else drv[k].i_req = 1'b0;
    drv[k].i_cancel = 1'b0;
    if (v.d_first ? v.ri : v.rd) begin
      if (v.d_first) serve_i(v); else serve_d(v);
      @(negedge clk);
      drv[k].i_req = 1'b0;
      drv[k].d_req = 1'b0;
      drv[k].i_cancel = 1'b0;
    end
  endtask

  function automatic vec_t mk(int k, bit ri, bit rd, bit wr, logic [1:0] sz,
                              logic [31:0] ia, logic [31:0] da, logic [31:0] wd,
                              logic [31:0] ird, logic [31:0] drd,
                              int ai, int bi, int li, int ad, int bd, int ld, int cc, bit df);
    vec_t v;
    v.k = k; v.ri = ri; v.rd = rd; v.wr = wr; v.sz = sz;
    v.ia = ia; v.da = da; v.wd = wd; v.ird = ird; v.drd = drd;
    v.ai = ai; v.bi = bi; v.li = li; v.ad = ad; v.bd = bd; v.ld = ld;
    v.cc = cc; v.d_first = df;
    return v;
  endfunction

  vec_t tbl [12];

  initial begin
    tbl[0]  = mk(0, 1, 0, 0, 2'd2, 32'h0000_0100, 32'h0, 32'h0, 32'h2408_0005, 32'h0,
                 0, 1, 3, 0, 0, 0, 0, 1'b0);
    tbl[1]  = mk(0, 1, 1, 1, 2'd2, 32'h0000_0104, 32'h8000_0010, 32'hDEAD_BEEF, 32'h1111_2222, 32'h0,
                 0, 1, 3, 0, 1, 3, 0, 1'b1);
    tbl[2]  = mk(0, 0, 1, 0, 2'd1, 32'h0, 32'h1234_5678, 32'h0, 32'h0, 32'hCAFE_F00D,
                 0, 0, 0, 2, 4, 8, 0, 1'b1);
    tbl[3]  = mk(0, 1, 0, 0, 2'd2, 32'h0000_0200, 32'h0, 32'h0, 32'h0BAD_CAFE, 32'h0,
                 0, 0, 2, 0, 0, 0, 0, 1'b0);
    tbl[4]  = mk(0, 1, 0, 0, 2'd2, 32'h0000_0204, 32'h0, 32'h0, 32'h5555_5555, 32'h0,
                 0, 2, 4, 0, 0, 0, 2, 1'b0);
    tbl[5]  = mk(0, 0, 1, 0, 2'd0, 32'h0, 32'h0000_0300, 32'h0, 32'h0, 32'h0000_00A5,
                 0, 0, 0, 1, 1, 4, 0, 1'b1);
    tbl[6]  = mk(0, 1, 0, 0, 2'd2, 32'h0000_0208, 32'h0, 32'h0, 32'h6666_7777, 32'h0,
                 0, 1, 3, 0, 0, 0, 3, 1'b0);
    tbl[7]  = mk(0, 1, 0, 0, 2'd2, 32'h0000_020C, 32'h0, 32'h0, 32'h8888_9999, 32'h0,
                 2, 1, 5, 0, 0, 0, 1, 1'b0);
    tbl[8]  = mk(1, 1, 1, 1, 2'd0, 32'h0000_0400, 32'h0000_0500, 32'h0000_00EE, 32'h1357_2468, 32'h0,
                 0, 1, 3, 0, 1, 3, 0, 1'b1);
    tbl[9]  = mk(1, 0, 1, 0, 2'd2, 32'h0, 32'h0000_0504, 32'h0, 32'h0, 32'h600D_F00D,
                 0, 0, 0, 1, 0, 3, 0, 1'b1);
    tbl[10] = mk(1, 1, 1, 0, 2'd1, 32'h0000_0404, 32'h0000_0508, 32'h0, 32'hA1A2_A3A4, 32'h0000_BEEF,
                 1, 2, 5, 0, 0, 2, 0, 1'b0);
    tbl[11] = mk(1, 1, 1, 0, 2'd2, 32'h0000_0408, 32'h0000_050C, 32'h0, 32'h1212_1212, 32'h3434_3434,
                 0, 1, 3, 0, 1, 3, 0, 1'b0);

    drv[0] = '0;
    drv[1] = '0;
    last[0] = 1'b0;
    last[1] = 1'b0;
    resetn = 1'b0;
    #12;
    chk_reset(0, "por");
    chk_reset(1, "por");
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 12; i++) round(tbl[i]);

    // Cancel in IDLE blocks that cycle's fetch grant only.
    @(negedge clk);
    drv[0].i_req = 1'b1; drv[0].i_addr = 32'h0000_0600; drv[0].i_cancel = 1'b1;
    @(negedge clk);
    chk("idle cancel bus_req", 32'(mon[0].bus_req), 32'd0);
    chk("idle cancel state", 32'(mon[0].dbg), 32'd0);
    drv[0].i_cancel = 1'b0;
    serve(0, 1'b0, 0, 1, 3, 0, 1'b0, 2'd2, 32'h0000_0600, 32'h0, 32'h7777_8888);
    last[0] = 1'b0;
    @(negedge clk);
    drv[0].i_req = 1'b0;

    for (int r = 0; r < 40; r++) begin
      vec_t v;
      int   sel;
      sel = $urandom_range(2, 0);
      v = mk($urandom_range(1, 0), sel != 1, sel != 0, 1'(($urandom_range(1, 0))),
             2'($urandom_range(2, 0)), $urandom, $urandom, $urandom, $urandom, $urandom,
             $urandom_range(3, 0), $urandom_range(3, 0), 0,
             $urandom_range(3, 0), $urandom_range(3, 0), 0, 0, 1'b0);
      v.li = 2 + v.ai + v.bi;
      v.ld = 2 + v.ad + v.bd;
      if (v.ri && $urandom_range(3, 0) == 0) v.cc = $urandom_range(v.li, 1);
      v.d_first = v.rd && (v.k == 0 || last[v.k] == 1'b0 || !v.ri);
      round(v);
    end

    // Asynchronous reset while a fetch sits in DATA.
    @(negedge clk);
    drv[0].i_req = 1'b1; drv[0].i_addr = 32'h0000_0700;
    @(negedge clk);
    drv[0].addr_ok = 1'b1;
    @(negedge clk);
    drv[0].addr_ok = 1'b0;
    chk("pre-reset state", 32'(mon[0].dbg), 32'd2);
    #2;
    resetn = 1'b0;
    #1;
    chk_reset(0, "async");
    chk_reset(1, "async");
    @(negedge clk);
    chk("in-reset dones", 32'({mon[0].i_done, mon[0].d_done}), 32'd0);
    drv[0].i_req = 1'b0;
    resetn = 1'b1;
    last[0] = 1'b0;
    last[1] = 1'b0;
    round(mk(0, 1, 0, 0, 2'd2, 32'h0000_0800, 32'h0, 32'h0, 32'h3141_5926, 32'h0,
             0, 1, 3, 0, 0, 0, 0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
